umi_mem_device: RTL and testbench

Parametrised single-port UMI memory endpoint, the successor to `umiram`. It accepts UMI read, write and posted-write requests on a device request channel and executes them against an internal word-organised memory with byte-granular writes. It returns read and write-ack responses through a bounded response FIFO with full backpressure. It sits behind a `umi_rx_sim`/`umi_tx_sim` pair in simulation benches, or behind a UMI crossbar in SoC builds.

---
 rtl/umi_mem_pkg.sv | 38 +++
 rtl/umi_mem_resp_fifo.sv | 54 +++++
 rtl/umi_mem_device.sv | 188 ++++++++++++++++++
 tb/tb_umi_mem_device.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/umi_mem_pkg.sv
// umi_mem_pkg: shared constants, field layout and helpers for the UMI memory
// endpoint. Holds the UMI opcodes, the cmd field offsets/widths, the byte
// count helper and the response payload bundle at the default bus widths.
package umi_mem_pkg;

  localparam logic [4:0] UMI_REQ_RD       = 5'h01;
  localparam logic [4:0] UMI_RESP_RD      = 5'h02;
  localparam logic [4:0] UMI_REQ_WR       = 5'h03;
  localparam logic [4:0] UMI_RESP_WR      = 5'h04;
  localparam logic [4:0] UMI_REQ_WRPOSTED = 5'h05;

  localparam int UMI_OPC_LSB  = 0;
  localparam int UMI_OPC_W    = 5;
  localparam int UMI_SIZE_LSB = 5;
  localparam int UMI_SIZE_W   = 3;
  localparam int UMI_LEN_LSB  = 8;
  localparam int UMI_LEN_W    = 8;

  localparam int UMI_DW = 256;
  localparam int UMI_AW = 64;
  localparam int UMI_CW = 32;

  // Response payload at the default widths; the device builds the same
  // layout at its own parameter widths.
  typedef struct packed {
    logic [UMI_CW-1:0] cmd;
    logic [UMI_AW-1:0] dstaddr;
    logic [UMI_AW-1:0] srcaddr;
    logic [UMI_DW-1:0] data;
  } umi_resp_t;

  // Transfer size in bytes: (len+1) << size. Max 256<<7 fits in 32 bits.
  function automatic logic [31:0] umi_bytes(input logic [UMI_SIZE_W-1:0] size,
                                            input logic [UMI_LEN_W-1:0]  len);
    return (32'(len) + 32'd1) << size;
  endfunction

endpackage

// File: rtl/umi_mem_resp_fifo.sv
// umi_mem_resp_fifo: synchronous FIFO holding UMI responses.
// Ports:
//   clk, nreset        clock, async active-low reset (pointers and count)
//   push_i, din_i      write side; a push into a full FIFO is ignored
//   pop_i              read side; a pop of an empty FIFO is ignored
//   dout_o             head entry (meaningful only while count_o != 0)
//   count_o            number of stored entries
module umi_mem_resp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     nreset,
  input  logic                     push_i,
  input  logic [W-1:0]             din_i,
  input  logic                     pop_i,
  output logic [W-1:0]             dout_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q;
  logic          push_ok, pop_ok;

  assign push_ok = push_i && (count_q != (PW+1)'(DEPTH));
  assign pop_ok  = pop_i  && (count_q != '0);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  // Storage is not reset; the count qualifies it.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/umi_mem_device.sv
// umi_mem_device: single-port UMI memory endpoint.
// Executes UMI read / write / posted-write requests against an internal
// DW-bit word memory with byte-granular writes and returns RESP_RD/RESP_WR
// responses through a bounded FIFO.
// Ports:
//   clk, nreset                 clock, async active-low reset
//   udev_req_*                  request channel (valid/ready, cmd, addrs, data)
//   udev_resp_*                 response channel (valid/ready, cmd, addrs, data)
//   err_count                   saturating count of rejected requests
module umi_mem_device
  import umi_mem_pkg::*;
#(
  parameter int DW         = 256,
  parameter int AW         = 64,
  parameter int CW         = 32,
  parameter int DEPTH      = 1024,
  parameter int RESP_DEPTH = 4
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          udev_req_valid,
  output logic          udev_req_ready,
  input  logic [CW-1:0] udev_req_cmd,
  input  logic [AW-1:0] udev_req_dstaddr,
  input  logic [AW-1:0] udev_req_srcaddr,
  input  logic [DW-1:0] udev_req_data,
  output logic          udev_resp_valid,
  input  logic          udev_resp_ready,
  output logic [CW-1:0] udev_resp_cmd,
  output logic [AW-1:0] udev_resp_dstaddr,
  output logic [AW-1:0] udev_resp_srcaddr,
  output logic [DW-1:0] udev_resp_data,
  output logic [15:0]   err_count
);
  localparam int BW   = DW / 8;
  localparam int OW   = $clog2(BW);
  localparam int IW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(RESP_DEPTH) + 1;

  typedef struct packed {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dstaddr;
    logic [AW-1:0] srcaddr;
    logic [DW-1:0] data;
  } resp_t;

  // ---------------- request decode ----------------
  logic [UMI_OPC_W-1:0] opc;
  logic [OW-1:0]        off;
  logic [IW-1:0]        idx;
  logic [31:0]          nbytes, off32, end32;
  logic                 opc_rd, opc_wr, opc_wrp, req_ok, accept;
  logic                 do_wr, do_rd, need_resp, err_inc;
  logic [BW-1:0]        be;
  logic [DW-1:0]        wdata_sh;

  assign opc    = udev_req_cmd[UMI_OPC_LSB +: UMI_OPC_W];
  assign off    = udev_req_dstaddr[OW-1:0];
  assign idx    = udev_req_dstaddr[OW +: IW];
  assign nbytes = umi_bytes(udev_req_cmd[UMI_SIZE_LSB +: UMI_SIZE_W],
                            udev_req_cmd[UMI_LEN_LSB  +: UMI_LEN_W]);
  assign off32  = 32'(off);
  assign end32  = off32 + nbytes;

  assign opc_rd  = (opc == UMI_REQ_RD);
  assign opc_wr  = (opc == UMI_REQ_WR);
  assign opc_wrp = (opc == UMI_REQ_WRPOSTED);
  assign req_ok  = (opc_rd || opc_wr || opc_wrp) && (end32 <= 32'(BW));

  assign accept    = udev_req_valid && udev_req_ready;
  assign do_wr     = accept && req_ok && (opc_wr || opc_wrp);
  assign do_rd     = accept && req_ok && opc_rd;
  assign need_resp = accept && req_ok && (opc_rd || opc_wr);
  assign err_inc   = accept && !req_ok;

  // Byte lane b is written when off <= b < off+N; data byte 0 lands at lane off.
  always_comb begin
    be = '0;
    for (int b = 0; b < BW; b++)
      be[b] = (32'(b) >= off32) && (32'(b) < end32);
  end
  assign wdata_sh = udev_req_data << {off, 3'b000};

  // ---------------- memory ----------------
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_word_q;

  always_ff @(posedge clk) begin
    if (do_wr)
      for (int b = 0; b < BW; b++)
        if (be[b]) mem_q[idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
    if (do_rd) rd_word_q <= mem_q[idx];
  end

  // ---------------- response pipeline stage ----------------
  logic          stg_vld_q, stg_rd_q;
  logic [CW-1:0] stg_cmd_q;
  logic [AW-1:0] stg_dst_q, stg_src_q;
  logic [OW-1:0] stg_off_q;
  logic [31:0]   stg_nb_q;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      stg_vld_q <= 1'b0;
      stg_rd_q  <= 1'b0;
      stg_cmd_q <= '0;
      stg_dst_q <= '0;
      stg_src_q <= '0;
      stg_off_q <= '0;
      stg_nb_q  <= '0;
    end else begin
      stg_vld_q <= need_resp;
      if (need_resp) begin
        stg_rd_q  <= opc_rd;
        stg_cmd_q <= udev_req_cmd;
        stg_dst_q <= udev_req_dstaddr;
        stg_src_q <= udev_req_srcaddr;
        stg_off_q <= off;
        stg_nb_q  <= nbytes;
      end
    end
  end

  // Align the read word down to byte 0 and zero everything past N.
  resp_t         push_pl;
  logic [DW-1:0] rd_sh;

  assign rd_sh = rd_word_q >> {stg_off_q, 3'b000};

  always_comb begin
    push_pl         = '0;
    push_pl.cmd     = {stg_cmd_q[CW-1:UMI_OPC_W], stg_rd_q ? UMI_RESP_RD : UMI_RESP_WR};
    push_pl.dstaddr = stg_src_q;
    push_pl.srcaddr = stg_dst_q;
    if (stg_rd_q)
      for (int b = 0; b < BW; b++)
        push_pl.data[b*8 +: 8] = (32'(b) < stg_nb_q) ? rd_sh[b*8 +: 8] : 8'h00;
  end

  // ---------------- response FIFO ----------------
  resp_t           head;
  logic [CNTW-1:0] fifo_cnt;
  logic [CNTW:0]   occ;

  umi_mem_resp_fifo #(
    .DEPTH (RESP_DEPTH),
    .W     ($bits(resp_t))
  ) u_resp_fifo (
    .clk     (clk),
    .nreset  (nreset),
    .push_i  (stg_vld_q),
    .din_i   (push_pl),
    .pop_i   (udev_resp_valid && udev_resp_ready),
    .dout_o  (head),
    .count_o (fifo_cnt)
  );

  // Ready counts the in-flight stage so a push can never hit a full FIFO;
  // it deliberately ignores request contents.
  assign occ            = {1'b0, fifo_cnt} + {{CNTW{1'b0}}, stg_vld_q};
  assign udev_req_ready = nreset && (occ < (CNTW+1)'(RESP_DEPTH));

  assign udev_resp_valid   = (fifo_cnt != '0);
  assign udev_resp_cmd     = udev_resp_valid ? head.cmd     : '0;
  assign udev_resp_dstaddr = udev_resp_valid ? head.dstaddr : '0;
  assign udev_resp_srcaddr = udev_resp_valid ? head.srcaddr : '0;
  assign udev_resp_data    = udev_resp_valid ? head.data    : '0;

  // ---------------- error counter ----------------
  logic [15:0] err_d, err_q;

  always_comb begin
    err_d = err_q;
    if (err_inc && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) err_q <= '0;
    else         err_q <= err_d;
  end

  assign err_count = err_q;

  // Upper address bits alias by design.
  logic unused_addr;
  assign unused_addr = ^udev_req_dstaddr[AW-1:OW+IW];

endmodule

// File: tb/tb_umi_mem_device.sv
module tb_umi_mem_device;
  logic         clk = 1'b0;
  logic         nreset = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [31:0]  req_cmd = '0;
  logic [63:0]  req_dst = '0, req_src = '0;
  logic [255:0] req_data = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b1;
  logic [31:0]  resp_cmd;
  logic [63:0]  resp_dst, resp_src;
  logic [255:0] resp_data;
  logic [15:0]  err_count;

  int n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  umi_mem_device #(.DW(256), .AW(64), .CW(32), .DEPTH(1024), .RESP_DEPTH(4)) dut (
    .clk               (clk),
    .nreset            (nreset),
    .udev_req_valid    (req_valid),
    .udev_req_ready    (req_ready),
    .udev_req_cmd      (req_cmd),
    .udev_req_dstaddr  (req_dst),
    .udev_req_srcaddr  (req_src),
    .udev_req_data     (req_data),
    .udev_resp_valid   (resp_valid),
    .udev_resp_ready   (resp_ready),
    .udev_resp_cmd     (resp_cmd),
    .udev_resp_dstaddr (resp_dst),
    .udev_resp_srcaddr (resp_src),
    .udev_resp_data    (resp_data),
    .err_count         (err_count)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h exp %h", tag, got, exp);
  endtask

  // Drive one request at a negedge, wait (bounded) for ready, accept at posedge.
  task automatic req(input logic [31:0] cmd, input logic [63:0] dst, input logic [63:0] src,
                     input logic [255:0] data);
    @(negedge clk);
    req_valid = 1'b1; req_cmd = cmd; req_dst = dst; req_src = src; req_data = data;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    if (!req_ready) chk("req_timeout", 0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for a response; lat = accept-to-visible edges.
  task automatic wait_resp(output logic [31:0] c, output logic [63:0] d, output logic [63:0] s,
                           output logic [255:0] dat, output int lat);
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (resp_valid) break;
    end
    if (!resp_valid) chk("resp_timeout", 0, 1);
    c = resp_cmd; d = resp_dst; s = resp_src; dat = resp_data;
  endtask

  task automatic no_resp(input string tag, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      seen |= resp_valid;
    end
    chk(tag, seen, 1'b0);
  endtask

  initial begin
    logic [31:0]  c;
    logic [63:0]  d, s;
    logic [255:0] dat;
    int           lat, acc;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_err", err_count, 0);
    chk("rst_cmd", resp_cmd, 0);
    chk("rst_data", resp_data, 0);
    nreset = 1'b1;
    #1 chk("rel_ready", req_ready, 1);

    // write then read
    req(32'h63, 64'h40, 64'h1000, 256'h1122334455667788);
    wait_resp(c, d, s, dat, lat);
    chk("wr_cmd", c, 32'h64);
    chk("wr_dst", d, 64'h1000);
    chk("wr_src", s, 64'h40);
    chk("wr_data", dat, 0);
    chk("wr_lat", lat, 1);
    req(32'h61, 64'h40, 64'h2000, 0);
    wait_resp(c, d, s, dat, lat);
    chk("rd_cmd", c, 32'h62);
    chk("rd_dst", d, 64'h2000);
    chk("rd_data", dat, 256'h1122334455667788);
    chk("rd_lat", lat, 1);

    // partial posted write: 2 bytes at offset 3
    req(32'h105, 64'h43, 64'h0, 256'hBEEF);
    no_resp("posted_noresp", 4);
    req(32'h61, 64'h40, 64'h3000, 0);
    wait_resp(c, d, s, dat, lat);
    chk("part_data", dat, 256'h112233BEEF667788);
    @(posedge clk); #1;

    // backpressure: stall responses and stream reads
    resp_ready = 1'b0;
    acc = 0;
    @(negedge clk);
    req_valid = 1'b1; req_cmd = 32'h61; req_dst = 64'h40; req_data = '0;
    for (int i = 0; i < 8; i++) begin
      req_src = 64'(acc);
      if (req_ready) acc++;
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("bp_accepted", acc, 4);
    chk("bp_ready_lo", req_ready, 0);
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", resp_valid, 1);
      chk("bp_order", resp_dst, 64'(i));
      if (i == 0) chk("bp_data", resp_data, 256'h112233BEEF667788);
      @(posedge clk);
      @(negedge clk);
      if (i == 0) chk("bp_ready_back", req_ready, 1);
    end
    chk("bp_drained", resp_valid, 0);

    // errors, boundary, aliasing
    req(32'h09, 64'h0, 64'h0, 0);
    chk("err_opc", err_count, 1);
    no_resp("err_opc_noresp", 4);
    req(32'h63, 64'h1C, 64'h0, 256'hFFFF);
    chk("err_ovf", err_count, 2);
    no_resp("err_ovf_noresp", 4);
    req(32'h65, 64'h18, 64'h0, 256'h0123456789ABCDEF);
    req(32'h61, 64'h18, 64'h55, 0);
    wait_resp(c, d, s, dat, lat);
    chk("edge_data", dat, 256'h0123456789ABCDEF);
    chk("edge_err", err_count, 2);
    req(32'h65, 64'h8000, 64'h0, 256'hA5A50000DEADBEEF);
    req(32'h61, 64'h0, 64'h77, 0);
    wait_resp(c, d, s, dat, lat);
    chk("alias_data", dat, 256'hA5A50000DEADBEEF);
    @(posedge clk); #1;

    // reset mid-operation with 3 responses queued
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) req(32'h61, 64'h40, 64'(i), 0);
    repeat (2) @(negedge clk);
    chk("mid_valid_pre", resp_valid, 1);
    nreset = 1'b0;
    #1;
    chk("mid_valid_rst", resp_valid, 0);
    chk("mid_ready_rst", req_ready, 0);
    @(negedge clk);
    nreset = 1'b1;
    #1;
    chk("mid_ready_rel", req_ready, 1);
    chk("mid_err", err_count, 0);
    resp_ready = 1'b1;
    no_resp("mid_no_stale", 6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
